mod_mult_iter: RTL
==================

// Module: mod_mult_iter
// PURPOSE
//  Iterative, parametrised multiply/square unit; successor to the fixed 8-bit squarer.
//  Computes a*a, a*b, (a*a) mod m or (a*b) mod m, one operand bit per clock.
//  Modular modes use MSB-first Blakley interleaved reduction.
//  Feeds the keychain exponentiation datapath; same ready/busy/valid handshake style.
// PARAMETERS
//  WIDTH  8  operand and modulus width in bits (>=2); result_out is 2*WIDTH
// PORTS
//  clk_in      in   1        single clock, rising edge
//  rst_n_in    in   1        asynchronous, active-low reset
//  ready_in    in   1        start request; accepted only when busy_out==0
//  mode_in     in   2        00 SQ, 01 MUL, 10 MODSQ, 11 MODMUL; sampled at accept
//  a_in        in   WIDTH    operand a; sampled at accept
//  b_in        in   WIDTH    operand b; ignored in SQ/MODSQ (b:=a); sampled at accept
//  mod_in      in   WIDTH    modulus m; modular modes only; sampled at accept
//  result_out  out  2*WIDTH  product; modular result zero-extended; held until next result
//  busy_out    out  1        high from accept edge until result edge
//  valid_out   out  1        one-cycle pulse: result_out/error_out are valid
//  error_out   out  1        qualified by valid_out: illegal modular operands
// BEHAVIOUR
//  Reset (async, rst_n_in=0): state=IDLE, result_out=0, busy_out=0, valid_out=0, error_out=0,
//   all internal regs 0. Asserting reset mid-operation aborts the operation; no valid_out follows.
//  All outputs are registered.
//  Accept edge E0: ready_in=1 in IDLE -> latch mode/a/b/m, r=0, bit index=WIDTH-1, busy_out=1.
//   Operand check at E0 (modular modes only): m==0, b>=m, or a>=m (MODSQ) -> state=ERR.
//   Otherwise -> CALC.
//  CALC, edges E1..E_WIDTH: take bit i=a[idx], idx decrements.
//   Plain modes: r = 2r + (i ? b : 0). r is 2*WIDTH wide and cannot overflow.
//   Modular modes: t = 2r + (i ? b : 0), computed WIDTH+2 wide.
//    Invariant r<m gives t<3m; subtract m at most twice so r<m again. One combinational step.
//  At edge E_WIDTH: result_out<=r_final, valid_out<=1, error_out<=0, busy_out<=0, state=IDLE.
//   Latency: result is visible WIDTH cycles after the accept edge.
//  ERR, edge E1: result_out<=0, valid_out<=1, error_out<=1, busy_out<=0, state=IDLE.
//  valid_out is high exactly one cycle. error_out is cleared on the next accept.
//  ready_in while busy_out=1 is ignored: no queueing, no effect on the in-flight result.
//  Back-to-back: ready_in in the valid_out cycle is accepted (busy_out is already 0).
//  Input changes after accept do not affect the in-flight operation.
// STRUCTURE
//  Shared package keychain_arith_pkg:
//   mode_e {MODE_SQ, MODE_MUL, MODE_MODSQ, MODE_MODMUL}
//   state_e {IDLE, CALC, ERR}
//   helper function is_mod(mode_e)
//  Sub-module blakley_step (combinational, WIDTH param): in r, b, m, bit; out reduced r.
//  Top level holds the FSM, bit counter ($clog2(WIDTH) bits), operand regs and the plain-mode path.
// TESTING (WIDTH=8 unless noted)
//  SQ a=255, pulse ready_in -> busy 8 cycles, then valid_out pulse, result_out=16'hFE01, error_out=0.
//  MUL a=200 b=3 -> result_out=600; MUL a=0 b=255 -> 0; MUL a=255 b=255 -> 16'hFE01.
//  MODSQ a=10 m=13 -> 9; MODMUL a=12 b=11 m=13 -> 2; MODMUL a=254 b=254 m=255 -> 1.
//  MODMUL m=0, and MODMUL b=20 m=13 -> valid_out 1 cycle after accept, error_out=1, result_out=0.
//  ready_in held high through an op -> result unchanged; re-accept in the valid_out cycle;
//   second op correct.
//  rst_n_in low at iteration 4 -> all outputs 0 immediately, no valid_out; next op correct.
//   Repeat with WIDTH=16: MUL 65535*65535=32'hFFFE0001.

Source files
------------

// File: rtl/keychain_arith_pkg.sv
// Shared types for the keychain arithmetic blocks: operation modes, FSM states
// and the mode classification helper.
package keychain_arith_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SQ     = 2'b00,
    MODE_MUL    = 2'b01,
    MODE_MODSQ  = 2'b10,
    MODE_MODMUL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    ERR  = 2'b10
  } state_e;

  function automatic logic is_mod(input mode_e mode);
    return (mode == MODE_MODSQ) || (mode == MODE_MODMUL);
  endfunction

  function automatic logic is_square(input mode_e mode);
    return (mode == MODE_SQ) || (mode == MODE_MODSQ);
  endfunction

endpackage

// File: rtl/mod_mult_iter_if.sv
// Request/result bundle of the iterative multiplier: start handshake and
// operands in, product with busy/valid/error status out.
interface mod_mult_iter_if #(
  parameter int WIDTH = 8
);
  logic                 ready_in;
  logic [1:0]           mode_in;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIDTH-1:0]     mod_in;
  logic [2*WIDTH-1:0]   result_out;
  logic                 busy_out;
  logic                 valid_out;
  logic                 error_out;

  modport master (
    output ready_in, mode_in, a_in, b_in, mod_in,
    input  result_out, busy_out, valid_out, error_out
  );

  modport slave (
    input  ready_in, mode_in, a_in, b_in, mod_in,
    output result_out, busy_out, valid_out, error_out
  );
endinterface

// File: rtl/blakley_step.sv
// One MSB-first Blakley iteration: r' = (2r + bit*b) mod m, assuming r<m and b<m.
// Because the sum stays below 3m, two conditional subtractions finish the reduction.
module blakley_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] r_o
);
  localparam int TW = WIDTH + 2;

  logic [TW-1:0] m_ext;
  logic [TW-1:0] sum;
  logic [TW-1:0] once;
  logic [TW-1:0] twice;

  always_comb begin
    m_ext = {2'b00, m_i};
    sum   = {1'b0, r_i, 1'b0} + (bit_i ? {2'b00, b_i} : {TW{1'b0}});
    once  = (sum >= m_ext) ? (sum - m_ext) : sum;
    twice = (once >= m_ext) ? (once - m_ext) : once;
    r_o   = twice[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_mult_iter.sv
// Iterative multiply/square unit with optional modular reduction, consuming one
// bit of operand a per clock from the MSB down.
module mod_mult_iter
  import keychain_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  mod_mult_iter_if.slave bus
);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW    = 2 * WIDTH;

  state_e           state_q,  state_d;
  mode_e            mode_q,   mode_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH-1:0] m_q,      m_d;
  logic [RW-1:0]    r_q,      r_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [RW-1:0]    result_q, result_d;
  logic             busy_q,   busy_d;
  logic             valid_q,  valid_d;
  logic             error_q,  error_d;

  mode_e            in_mode;
  logic [WIDTH-1:0] in_b_eff;
  logic             in_bad;
  logic             cur_bit;
  logic [WIDTH-1:0] mod_r;
  logic [RW-1:0]    plain_r;
  logic [RW-1:0]    r_next;

  // Operand legality is decided from the raw inputs so ERR is entered on the accept edge.
  always_comb begin
    in_mode  = mode_e'(bus.mode_in);
    in_b_eff = is_square(in_mode) ? bus.a_in : bus.b_in;
    in_bad   = is_mod(in_mode) &&
               ((bus.mod_in == {WIDTH{1'b0}}) || (in_b_eff >= bus.mod_in));
  end

  assign cur_bit = a_q[idx_q];

  blakley_step #(.WIDTH(WIDTH)) u_step (
    .r_i   (r_q[WIDTH-1:0]),
    .b_i   (b_q),
    .m_i   (m_q),
    .bit_i (cur_bit),
    .r_o   (mod_r)
  );

  // Plain modes keep the full double-width accumulator; it never overflows.
  always_comb begin
    plain_r = {r_q[RW-2:0], 1'b0} + (cur_bit ? {{WIDTH{1'b0}}, b_q} : {RW{1'b0}});
    r_next  = is_mod(mode_q) ? {{WIDTH{1'b0}}, mod_r} : plain_r;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    r_d      = r_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    error_d  = error_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ready_in) begin
          mode_d  = in_mode;
          a_d     = bus.a_in;
          b_d     = in_b_eff;
          m_d     = bus.mod_in;
          r_d     = {RW{1'b0}};
          idx_d   = IDX_W'(WIDTH - 1);
          busy_d  = 1'b1;
          error_d = 1'b0;
          state_d = in_bad ? ERR : CALC;
        end
      end
      CALC: begin
        r_d   = r_next;
        idx_d = idx_q - 1'b1;
        if (idx_q == {IDX_W{1'b0}}) begin
          result_d = r_next;
          valid_d  = 1'b1;
          error_d  = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      ERR: begin
        result_d = {RW{1'b0}};
        valid_d  = 1'b1;
        error_d  = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      mode_q   <= MODE_SQ;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign bus.result_out = result_q;
  assign bus.busy_out   = busy_q;
  assign bus.valid_out  = valid_q;
  assign bus.error_out  = error_q;

endmodule
